// File: rtl/sgdmac_ar_arbiter_n.sv
// N-channel AXI read-address arbiter with RID-based read-response routing.
// Registered AR master port, round-robin or fixed-priority selection,
// per-channel outstanding-burst limits and a sticky bad-response flag.
module sgdmac_ar_arbiter_n #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prio_mode_i,
  input  logic [N_CH-1:0]        ch_en_i,
  input  logic [N_CH-1:0]        src_arvalid_i,
  output logic [N_CH-1:0]        src_arready_o,
  input  logic [N_CH*ADDR_W-1:0] src_araddr_i,
  input  logic [N_CH*LEN_W-1:0]  src_arlen_i,
  input  logic [N_CH*3-1:0]      src_arsize_i,
  input  logic [N_CH*2-1:0]      src_arburst_i,
  output logic [ID_W-1:0]        arid_o,
  output logic [ADDR_W-1:0]      araddr_o,
  output logic [LEN_W-1:0]       arlen_o,
  output logic [2:0]             arsize_o,
  output logic [1:0]             arburst_o,
  output logic                   arvalid_o,
  input  logic                   arready_i,
  input  logic [ID_W-1:0]        rid_i,
  input  logic                   rvalid_i,
  input  logic                   rlast_i,
  output logic                   rready_o,
  output logic [N_CH-1:0]        src_rvalid_o,
  input  logic [N_CH-1:0]        src_rready_i,
  output logic [N_CH-1:0]        outs_busy_o,
  output logic                   err_o
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);

  // Registered state
  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]   busy_q, busy_d;
  logic              err_q, err_d;

  // Combinational helpers
  logic [N_CH-1:0]   eligible;
  logic              load;
  logic [IDX_W-1:0]  grant_idx;
  logic [N_CH-1:0]   grant_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [2:0]        sel_size;
  logic [1:0]        sel_burst;
  logic [N_CH-1:0]   route_oh;
  logic              route;
  logic              rready_c;
  logic [N_CH-1:0]   dec;

  // Channel index at a given offset after the round-robin base
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    return IDX_W'(s % N_CH);
  endfunction

  // Requests that may be granted this cycle
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      eligible[k] = src_arvalid_i[k] & ch_en_i[k] & (cnt_q[k] < CNT_MAX);
    end
    load = (~arvalid_q | arready_i) & (|eligible);
  end

  // Winner selection; descending scans leave the highest-priority hit last
  always_comb begin
    grant_idx = '0;
    if (prio_mode_i) begin
      for (int unsigned i = N_CH; i > 0; i--) begin
        if (eligible[IDX_W'(i - 1)]) grant_idx = IDX_W'(i - 1);
      end
    end else begin
      for (int unsigned i = N_CH; i > 0; i--) begin
        if (eligible[rr_idx(last_grant_q, i)]) grant_idx = rr_idx(last_grant_q, i);
      end
    end
  end

  // Grant strobe and payload mux for the winning channel
  always_comb begin
    grant_oh  = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (IDX_W'(k) == grant_idx) begin
        grant_oh[k] = load;
        sel_addr    = src_araddr_i[k*ADDR_W +: ADDR_W];
        sel_len     = src_arlen_i[k*LEN_W +: LEN_W];
        sel_size    = src_arsize_i[k*3 +: 3];
        sel_burst   = src_arburst_i[k*2 +: 2];
      end
    end
  end

  // AR register next state: load on grant, hold while stalled, drop on drain
  always_comb begin
    arvalid_d    = load | (arvalid_q & ~arready_i);
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    last_grant_d = last_grant_q;
    if (load) begin
      arid_d       = ID_W'(grant_idx);
      araddr_d     = sel_addr;
      arlen_d      = sel_len;
      arsize_d     = sel_size;
      arburst_d    = sel_burst;
      last_grant_d = grant_idx;
    end
  end

  // Response routing: valid RID with a burst in flight, otherwise drain
  always_comb begin
    route_oh = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      route_oh[k] = (32'(rid_i) == k) & (cnt_q[k] != '0);
    end
    route    = |route_oh;
    rready_c = route ? |(route_oh & src_rready_i) : 1'b1;
    dec      = (rvalid_i & rready_c & rlast_i) ? route_oh : '0;
    err_d    = err_q | (rvalid_i & ~route);
  end

  // Outstanding counters; simultaneous inc/dec cancel
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      cnt_d[k]  = cnt_q[k];
      busy_d[k] = (cnt_q[k] != '0);
      if (grant_oh[k] & ~dec[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else if (dec[k] & ~grant_oh[k]) begin
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q    <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      last_grant_q <= IDX_W'(N_CH - 1);
      busy_q       <= '0;
      err_q        <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else begin
      arvalid_q    <= arvalid_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      for (int unsigned k = 0; k < N_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign src_arready_o = grant_oh;
  assign arvalid_o     = arvalid_q;
  assign arid_o        = arid_q;
  assign araddr_o      = araddr_q;
  assign arlen_o       = arlen_q;
  assign arsize_o      = arsize_q;
  assign arburst_o     = arburst_q;
  assign rready_o      = rready_c;
  assign src_rvalid_o  = rvalid_i ? route_oh : '0;
  assign outs_busy_o   = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sgdmac_ar_arbiter_n.sv
// Directed bench for sgdmac_ar_arbiter_n (N_CH=4, MAX_OUTS=2).
module tb_sgdmac_ar_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 4;
  localparam int IW = 4;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            prio_mode;
  logic [N-1:0]    ch_en;
  logic [N-1:0]    src_arvalid;
  logic [N-1:0]    src_arready;
  logic [N*AW-1:0] src_araddr;
  logic [N*LW-1:0] src_arlen;
  logic [N*3-1:0]  src_arsize;
  logic [N*2-1:0]  src_arburst;
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [LW-1:0]   arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [IW-1:0]   rid;
  logic            rvalid;
  logic            rlast;
  logic            rready;
  logic [N-1:0]    src_rvalid;
  logic [N-1:0]    src_rready;
  logic [N-1:0]    outs_busy;
  logic            err;

  int total = 0;
  int bad   = 0;

  sgdmac_ar_arbiter_n #(.N_CH(N), .ADDR_W(AW), .LEN_W(LW), .ID_W(IW), .MAX_OUTS(MO)) dut (
    .clk(clk), .rst(rst), .prio_mode_i(prio_mode), .ch_en_i(ch_en),
    .src_arvalid_i(src_arvalid), .src_arready_o(src_arready),
    .src_araddr_i(src_araddr), .src_arlen_i(src_arlen),
    .src_arsize_i(src_arsize), .src_arburst_i(src_arburst),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
    .arburst_o(arburst), .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rvalid_i(rvalid), .rlast_i(rlast), .rready_o(rready),
    .src_rvalid_o(src_rvalid), .src_rready_i(src_rready),
    .outs_busy_o(outs_busy), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] exp_addr(input int k);
    return 32'hA000_0000 + 32'(k) * 32'h100;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; prio_mode = 1'b0; ch_en = '1; src_arvalid = '0; arready = 1'b0;
    rid = '0; rvalid = 1'b0; rlast = 1'b0; src_rready = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b exp 0", arvalid); end
    total++; if (araddr !== '0 || arid !== '0 || arlen !== '0) begin bad++; $display("FAIL reset_payload: got addr %h id %h len %h exp 0", araddr, arid, arlen); end
    total++; if (outs_busy !== '0 || err !== 1'b0) begin bad++; $display("FAIL reset_busy_err: got busy %b err %b exp 0", outs_busy, err); end
    total++; if (src_arready !== '0 || src_rvalid !== '0) begin bad++; $display("FAIL reset_comb: got arready %b rvalid %b exp 0", src_arready, src_rvalid); end
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL reset_rready_drain: got %b exp 1", rready); end
  endtask

  task automatic test_rr_fairness();
    int e;
    logic [N-1:0] exp_oh;
    src_arvalid = 4'hF; arready = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      e = j % N;
      exp_oh = 4'(1 << e);
      total++; if (src_arready !== exp_oh) begin bad++; $display("FAIL rr_ready[%0d]: got %b exp %b", j, src_arready, exp_oh); end
      step();
      total++;
      if (arvalid !== 1'b1 || arid !== 4'(e) || araddr !== exp_addr(e) || arlen !== 4'(e + 1)) begin
        bad++; $display("FAIL rr_ar[%0d]: got v %b id %0d addr %h len %0d exp v 1 id %0d addr %h len %0d", j, arvalid, arid, araddr, arlen, e, exp_addr(e), e + 1);
      end
    end
    total++; if (src_arready !== '0) begin bad++; $display("FAIL rr_limit_ready: got %b exp 0", src_arready); end
    total++; if (outs_busy !== 4'hF) begin bad++; $display("FAIL rr_busy: got %b exp 1111", outs_busy); end
    step();
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rr_drain_arvalid: got %b exp 0", arvalid); end
    apply_reset();
  endtask

  task automatic test_fixed_prio();
    prio_mode = 1'b1; src_arvalid = 4'b1010; arready = 1'b1;
    #1;
    total++; if (src_arready !== 4'b0010) begin bad++; $display("FAIL fp_first_ready: got %b exp 0010", src_arready); end
    step();
    total++; if (arid !== 4'd1 || arvalid !== 1'b1) begin bad++; $display("FAIL fp_first_id: got %0d v %b exp 1 v 1", arid, arvalid); end
    rid = 4'd1; rvalid = 1'b1; rlast = 1'b1; src_rready = 4'hF;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (src_arready !== 4'b0010) begin bad++; $display("FAIL fp_ready[%0d]: got %b exp 0010", c, src_arready); end
      total++; if (src_rvalid !== 4'b0010 || rready !== 1'b1) begin bad++; $display("FAIL fp_route[%0d]: got rv %b rr %b exp 0010 1", c, src_rvalid, rready); end
      step();
      total++; if (arid !== 4'd1 || arvalid !== 1'b1) begin bad++; $display("FAIL fp_id[%0d]: got %0d v %b exp 1 v 1", c, arid, arvalid); end
    end
    src_arvalid = 4'b1000; rvalid = 1'b0; rlast = 1'b0;
    #1;
    total++; if (src_arready !== 4'b1000) begin bad++; $display("FAIL fp_ch3_ready: got %b exp 1000", src_arready); end
    step();
    total++; if (arid !== 4'd3 || err !== 1'b0) begin bad++; $display("FAIL fp_ch3_id: got id %0d err %b exp 3 0", arid, err); end
    apply_reset();
  endtask

  task automatic test_backpressure();
    arready = 1'b0; src_arvalid = 4'b0100;
    #1;
    total++; if (src_arready !== 4'b0100) begin bad++; $display("FAIL bp_first_ready: got %b exp 0100", src_arready); end
    step();
    total++; if (arvalid !== 1'b1 || arid !== 4'd2) begin bad++; $display("FAIL bp_load: got v %b id %0d exp 1 2", arvalid, arid); end
    src_arvalid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (src_arready !== '0) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %b exp 0", c, src_arready); end
      total++; if (arvalid !== 1'b1 || arid !== 4'd2 || araddr !== exp_addr(2)) begin bad++; $display("FAIL bp_hold_ar[%0d]: got v %b id %0d addr %h exp 1 2 %h", c, arvalid, arid, araddr, exp_addr(2)); end
      step();
    end
    arready = 1'b1;
    #1;
    total++; if (src_arready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready: got %b exp 0010", src_arready); end
    step();
    total++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== exp_addr(1)) begin bad++; $display("FAIL bp_release_ar: got v %b id %0d addr %h exp 1 1 %h", arvalid, arid, araddr, exp_addr(1)); end
    src_arvalid = '0;
    step();
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b exp 0", arvalid); end
    apply_reset();
  endtask

  task automatic test_outs_limit();
    src_arvalid = 4'b0001; arready = 1'b1;
    #1;
    total++; if (src_arready !== 4'b0001) begin bad++; $display("FAIL ol_ready0: got %b exp 0001", src_arready); end
    step();
    total++; if (src_arready !== 4'b0001) begin bad++; $display("FAIL ol_ready1: got %b exp 0001", src_arready); end
    step();
    total++; if (src_arready !== '0 || arvalid !== 1'b1 || arid !== 4'd0) begin bad++; $display("FAIL ol_blocked: got rdy %b v %b id %0d exp 0 1 0", src_arready, arvalid, arid); end
    step();
    total++; if (arvalid !== 1'b0 || outs_busy !== 4'b0001 || src_arready !== '0) begin bad++; $display("FAIL ol_idle: got v %b busy %b rdy %b exp 0 0001 0", arvalid, outs_busy, src_arready); end
    rid = 4'd0; rvalid = 1'b1; rlast = 1'b1; src_rready = 4'b0001;
    #1;
    total++; if (rready !== 1'b1 || src_rvalid !== 4'b0001 || src_arready !== '0) begin bad++; $display("FAIL ol_resp: got rr %b rv %b rdy %b exp 1 0001 0", rready, src_rvalid, src_arready); end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    total++; if (src_arready !== 4'b0001) begin bad++; $display("FAIL ol_regrant: got %b exp 0001", src_arready); end
    step();
    total++; if (arvalid !== 1'b1 || arid !== 4'd0) begin bad++; $display("FAIL ol_reload: got v %b id %0d exp 1 0", arvalid, arid); end
    apply_reset();
  endtask

  task automatic test_r_routing_err();
    src_arvalid = 4'b0100; arready = 1'b1;
    #1;
    step();
    src_arvalid = '0;
    #1;
    step();
    total++; if (arvalid !== 1'b0 || outs_busy !== 4'b0100) begin bad++; $display("FAIL rt_setup: got v %b busy %b exp 0 0100", arvalid, outs_busy); end
    rid = 4'd2; rvalid = 1'b1; rlast = 1'b0; src_rready = 4'b1011;
    #1;
    total++; if (rready !== 1'b0 || src_rvalid !== 4'b0100) begin bad++; $display("FAIL rt_route2: got rr %b rv %b exp 0 0100", rready, src_rvalid); end
    step();
    rid = 4'd5;
    #1;
    total++; if (rready !== 1'b1 || src_rvalid !== '0 || err !== 1'b0) begin bad++; $display("FAIL rt_drain5: got rr %b rv %b err %b exp 1 0 0", rready, src_rvalid, err); end
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rt_err_set: got %b exp 1", err); end
    rvalid = 1'b0;
    step();
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rt_err_sticky: got %b exp 1", err); end
    apply_reset();
  endtask

  task automatic test_simul_and_reset();
    src_arvalid = 4'b0001; arready = 1'b1;
    #1;
    step();
    rid = 4'd0; rvalid = 1'b1; rlast = 1'b1; src_rready = 4'b0001;
    #1;
    total++; if (src_arready !== 4'b0001 || rready !== 1'b1) begin bad++; $display("FAIL si_both: got rdy %b rr %b exp 0001 1", src_arready, rready); end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    total++; if (src_arready !== 4'b0001) begin bad++; $display("FAIL si_cnt_one: got %b exp 0001", src_arready); end
    step();
    total++; if (src_arready !== '0) begin bad++; $display("FAIL si_cnt_two: got %b exp 0", src_arready); end
    arready = 1'b0; src_arvalid = '0; rid = 4'd7; rvalid = 1'b1;
    #1;
    step();
    total++; if (err !== 1'b1 || arvalid !== 1'b1 || outs_busy !== 4'b0001) begin bad++; $display("FAIL si_pre_rst: got err %b v %b busy %b exp 1 1 0001", err, arvalid, outs_busy); end
    rvalid = 1'b0; rst = 1'b1;
    #1;
    step();
    total++; if (arvalid !== 1'b0 || outs_busy !== '0 || err !== 1'b0 || araddr !== '0) begin bad++; $display("FAIL si_rst: got v %b busy %b err %b addr %h exp 0 0 0 0", arvalid, outs_busy, err, araddr); end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      src_araddr[k*AW +: AW] = exp_addr(k);
      src_arlen[k*LW +: LW]  = 4'(k + 1);
      src_arsize[k*3 +: 3]   = 3'(k);
      src_arburst[k*2 +: 2]  = 2'b01;
    end
    test_reset();
    test_rr_fairness();
    test_fixed_prio();
    test_backpressure();
    test_outs_limit();
    test_r_routing_err();
    test_simul_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sgdmac_ar_arbiter_n.md
# sgdmac_ar_arbiter_n

Parametrised N-channel AXI read-address arbiter with read-response routing for the scatter-gather DMA. It generalises the fixed two-channel (descriptor fetcher + data reader) arbitration to N_CH requesters. It adds registered AR outputs, round-robin or fixed-priority selection, per-channel outstanding-burst limits, and R-channel demultiplexing by RID. It sits between all AR-issuing engines and the single AXI read port.

## Interface
- N_CH, 4: number of requesting channels (2..16).
- ADDR_W, 32: araddr width.
- LEN_W, 4: arlen width.
- ID_W, 4: arid/rid width; must be ≥ $clog2(N_CH).
- MAX_OUTS, 4: maximum outstanding bursts per channel (1..15).

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- prio_mode_i  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest); sampled every cycle.
- ch_en_i  in  N_CH  per-channel enable; a disabled channel is never granted.
- src_arvalid_i  in  N_CH  per-channel request.
- src_arready_o  out  N_CH  per-channel accept, one-hot or zero.
- src_araddr_i  in  N_CH*ADDR_W  packed; channel k at [k*ADDR_W +: ADDR_W].
- src_arlen_i  in  N_CH*LEN_W  packed, same layout.
- src_arsize_i  in  N_CH*3  packed.
- src_arburst_i  in  N_CH*2  packed.
- arid_o, araddr_o, arlen_o, arsize_o, arburst_o  out  ID_W/ADDR_W/LEN_W/3/2  registered master AR payload.
- arvalid_o  out  1  registered.
- arready_i  in  1  slave accept.
- rid_i  in  ID_W  response ID.
- rvalid_i, rlast_i  in  1  response valid / last beat.
- rready_o  out  1  combinational ready to slave.
- src_rvalid_o  out  N_CH  routed response valid (rdata is broadcast externally).
- src_rready_i  in  N_CH  per-channel response ready.
- outs_busy_o  out  N_CH  bit k = channel k has ≥1 outstanding burst.
- err_o  out  1  sticky: response arrived for an invalid or idle ID.

## Operation
- Eligible[k] = src_arvalid_i[k] & ch_en_i[k] & (outs_cnt[k] < MAX_OUTS).
- Load condition: (!arvalid_o | arready_i) & |eligible.
- Under the load condition, the winner g gets src_arready_o[g]=1 in that same cycle, combinationally. At the next edge g's payload is registered, arid_o = g zero-extended, and arvalid_o = 1.
- If arvalid_o & arready_i and nothing is eligible, arvalid_o goes to 0 at the next edge.
- While arvalid_o & !arready_i, the AR payload is frozen and src_arready_o = 0.
- Round-robin: search starts at last_grant+1 modulo N_CH. last_grant updates only on a load.
- Fixed priority: the lowest eligible index wins; last_grant still updates.
- Counters: outs_cnt[k], width $clog2(MAX_OUTS+1).
  - +1 on load for channel k.
  - −1 on rvalid_i & rready_o & rlast_i with rid_i == k.
  - Both in the same cycle on the same channel: unchanged.
  - A counter never wraps.
- R routing for valid rid_i < N_CH with outs_cnt[rid_i] > 0: src_rvalid_o[rid_i] = rvalid_i, others 0, rready_o = src_rready_i[rid_i].
- R routing when rid_i ≥ N_CH or outs_cnt[rid_i] == 0: all src_rvalid_o = 0 and rready_o = 1 (drain). err_o sets on any rvalid_i in this condition and stays set until rst.

## Timing
- Reset values:
  - arvalid_o 0 and all AR payload outputs 0.
  - last_grant = N_CH−1, so channel 0 wins first in round-robin.
  - All outs_cnt 0, outs_busy_o 0, err_o 0.
- Combinational outputs with no request present: src_arready_o 0, src_rvalid_o 0.
- Latency: source accept to arvalid_o is 1 cycle.
- Throughput: one AR per cycle when arready_i is held high, with back-to-back loads.
- AXI rule: once arvalid_o rises it stays high with a stable payload until arready_i.
- rst mid-burst: arvalid_o drops at the next edge without a handshake, and all counters clear. The system resets the slave together with this block.
- outs_busy_o is registered from the counters; it updates the cycle after the inc/dec edge.
- ch_en_i deassertion does not cancel an AR already registered.

## Test plan
- Round-robin fairness: N_CH=4, all four channels request continuously, arready_i=1, MAX_OUTS large, R idle with rlast returned promptly -> arid_o sequence 0,1,2,3,0,… with arvalid_o high every cycle after the first.
- Fixed priority: prio_mode_i=1, channels 1 and 3 request -> channel 1 is granted repeatedly; channel 3 is granted only after channel 1 drops src_arvalid_i.
- Backpressure: arready_i=0 for 5 cycles after arvalid_o rises -> araddr_o/arid_o stable, src_arready_o=0 throughout; the load happens in the cycle arready_i=1.
- Outstanding limit: MAX_OUTS=2, channel 0 issues 2 bursts with no responses -> third request not granted. Return rlast with rid=0 -> grant in the following cycle.
- R routing and error: rid_i=2 with outs_cnt[2]=1, src_rready_i[2]=0 -> rready_o=0, src_rvalid_o=4'b0100. Then rid_i=5 (N_CH=4) -> rready_o=1, err_o=1 next cycle and sticky.
- Simultaneous inc/dec plus mid-operation reset: load ch0 in the same cycle as ch0's rlast -> outs_cnt[0] unchanged. Assert rst while arvalid_o=1 -> arvalid_o=0, outs_busy_o=0, err_o=0 next cycle.
